mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter N, default 4, operand width and shift-add iteration count.
REQ-002 Parameter CNT_W, default 2, iteration counter width; SHALL equal clog2(N).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_valid  input  1  requester asks for a multiply; operands already on the datapath operand inputs.
REQ-006 start_ready  output  1  controller can accept a request; high only in IDLE.
REQ-007 abort  input  1  synchronous cancel of the operation in flight.
REQ-008 q0  input  1  datapath multiplier LSB.
REQ-009 ld_regs  output  1  datapath load strobe (M, Q, A clear).
REQ-010 add_en  output  1  datapath accumulate strobe.
REQ-011 shift_en  output  1  datapath right-shift strobe.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done_valid  output  1  product on datapath output is final.
REQ-014 done_ready  input  1  consumer accepts the product.

Function
REQ-015 FSM states IDLE, LOAD, TEST, ADD, SHIFT, DONE; all outputs Moore-decoded from the state register.
REQ-016 IDLE: start_ready=1; start_valid=1 -> LOAD next cycle; otherwise stay.
REQ-017 LOAD: ld_regs=1 for exactly one cycle; iteration counter cleared to 0; -> TEST.
REQ-018 TEST: no strobes; q0=1 -> ADD, q0=0 -> SHIFT.
REQ-019 ADD: add_en=1 for one cycle; -> SHIFT.
REQ-020 SHIFT: shift_en=1 for one cycle; counter increments; counter==N-1 at this cycle -> DONE, else -> TEST.
REQ-021 DONE: done_valid=1, held until done_ready=1; handshake cycle -> IDLE next cycle.
REQ-022 add_en and shift_en SHALL never be high in the same cycle; ld_regs SHALL never coincide with either.
REQ-023 Latency: with LOAD in cycle T and p = popcount(multiplier), first DONE cycle = T+1+2N+p (N=4: T+9..T+13).
REQ-024 Exactly N shift_en pulses and exactly p add_en pulses per completed operation.
REQ-025 start_valid outside IDLE ignored (start_ready=0); no queuing.
REQ-026 done_ready already high on DONE entry: DONE lasts one cycle, IDLE next; no back-to-back start from DONE.
REQ-027 abort=1 in any non-IDLE state: -> IDLE next cycle, no done_valid for that operation; abort in IDLE has no effect.
REQ-028 abort and start_valid together in IDLE: start accepted.
REQ-029 Counter wraps only through LOAD clear; never used outside LOAD..SHIFT.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE and counter 0, regardless of clk.
REQ-031 During and after reset: ld_regs=add_en=shift_en=busy=done_valid=0, start_ready=1.
REQ-032 Reset mid-operation discards the operation; no done_valid is produced for it.

Structure
REQ-033 Shared package mult_pkg SHALL hold the state encoding constants, default N and CNT_W.
REQ-034 One sub-module, iter_cnt (clear, increment, last flag), SHALL implement the iteration counter; FSM stays in mult_ctrl.
REQ-035 Design synthesizable, single clock domain, no latches.

Verification (bench instantiates mult_ctrl with the shift-add datapath)
REQ-036 multiplicand 3, multiplier 5, start pulse -> ld_regs at T, add_en at T+2 and T+7, 4 shift_en, done_valid at T+11, product 8'h0F.
REQ-037 multiplicand 9, multiplier 0 -> zero add_en pulses, done_valid at T+9, product 8'h00.
REQ-038 multiplicand 1, multiplier 15 -> 4 add_en pulses, done_valid at T+13, product 8'h0F.
REQ-039 done_ready low 5 cycles in DONE with start_valid high -> done_valid held, start_ready=0 throughout; ack -> IDLE next cycle, new start accepted.
REQ-040 rst asserted mid-ADD -> outputs per REQ-031 before next edge; abort in SHIFT -> IDLE next cycle, done_valid never rises.
REQ-041 Concurrent assertions over all tests: REQ-022 exclusivity, single-cycle ld_regs, busy == !start_ready.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encoding
// and default operand width / iteration counter width.
package mult_pkg;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mult_ctrl_iter_cnt.sv
// Iteration counter for the shift-add loop: cleared on load, bumped on each
// shift, flags the final iteration.
module iter_cnt
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Evaluated during SHIFT, before the increment lands.
  assign last_o = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Controller FSM for an N-bit shift-add multiplier datapath with
// valid/ready request and completion handshakes plus abort.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_valid,
  output logic start_ready,
  input  logic abort,
  input  logic q0,
  output logic ld_regs,
  output logic add_en,
  output logic shift_en,
  output logic busy,
  output logic done_valid,
  input  logic done_ready
);

  state_e state_q;
  state_e state_d;
  logic   cnt_last;

  iter_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (ld_regs),
    .inc_i  (shift_en),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort overrides every transition except from IDLE, where a start wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_valid) state_d = S_LOAD;
      S_LOAD:  state_d = S_TEST;
      S_TEST:  state_d = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = cnt_last ? S_DONE : S_TEST;
      S_DONE:  if (done_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    start_ready = 1'b0;
    ld_regs     = 1'b0;
    add_en      = 1'b0;
    shift_en    = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_LOAD:  ld_regs    = 1'b1;
      S_ADD:   add_en     = 1'b1;
      S_SHIFT: shift_en   = 1'b1;
      S_DONE:  done_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl driving a behavioural shift-add datapath; results are
// scored against arithmetic expectations queued at issue time.
module tb_mult_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_valid = 1'b0;
  logic abort = 1'b0;
  logic done_ready = 1'b0;
  logic start_ready, ld_regs, add_en, shift_en, busy, done_valid, q0;

  logic [N-1:0] mcand = '0;
  logic [N-1:0] mplier = '0;
  logic [N-1:0] A, Q, M;
  logic         C;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2*N-1:0] prod;
    int             lat;
    logic [31:0]    amask;
    logic [31:0]    smask;
  } exp_t;

  exp_t sb[$];

  mult_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .abort       (abort),
    .q0          (q0),
    .ld_regs     (ld_regs),
    .add_en      (add_en),
    .shift_en    (shift_en),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shift-add datapath controlled by the strobes
  always @(posedge clk) begin
    if (ld_regs) begin
      A <= '0; Q <= mplier; M <= mcand; C <= 1'b0;
    end else if (add_en) begin
      {C, A} <= {1'b0, A} + {1'b0, M};
    end else if (shift_en) begin
      {C, A, Q} <= {1'b0, C, A, Q[N-1:1]};
    end
  end
  assign q0 = Q[0];

  a_excl:    assert property (@(posedge clk) disable iff (rst) !(add_en && shift_en));
  a_ld_excl: assert property (@(posedge clk) disable iff (rst) ld_regs |-> !(add_en || shift_en));
  a_ld_one:  assert property (@(posedge clk) disable iff (rst) ld_regs |=> !ld_regs);
  a_busy:    assert property (@(posedge clk) busy == !start_ready);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Timeline from LOAD: each multiplier bit costs TEST, optional ADD, SHIFT.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   t;
    e.prod  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    e.lat   = 1 + 2 * N + $countones(b);
    e.amask = '0;
    e.smask = '0;
    t = 1;
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        e.amask[t + 1] = 1'b1;
        t++;
      end
      e.smask[t + 1] = 1'b1;
      t += 2;
    end
    return e;
  endfunction

  // Monitor: tracks strobes from each load, scores on done_valid rise
  initial begin
    int          t0;
    int          off;
    logic        in_op;
    logic        done_prev;
    logic [31:0] am, sm;
    exp_t        e;
    in_op = 1'b0; done_prev = 1'b0; t0 = 0; am = '0; sm = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_op = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (ld_regs) begin
          in_op = 1'b1; t0 = cyc; am = '0; sm = '0;
        end
        off = cyc - t0;
        if (in_op && off < 32) begin
          if (add_en)   am[off] = 1'b1;
          if (shift_en) sm[off] = 1'b1;
        end
        if (done_valid && !done_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("product", 32'({A, Q}), 32'(e.prod));
            chk("latency", 32'(off), 32'(e.lat));
            chk("add_pulses", am, e.amask);
            chk("shift_pulses", sm, e.smask);
          end
          in_op = 1'b0;
        end
        done_prev = done_valid;
      end
    end
  end

  // Structural invariants every cycle out of reset
  initial begin
    logic ld_prev;
    ld_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("excl_add_shift", 32'(add_en && shift_en), 32'd0);
        chk("excl_ld", 32'(ld_regs && (add_en || shift_en)), 32'd0);
        chk("busy_vs_ready", 32'(busy), 32'(!start_ready));
        chk("ld_single", 32'(ld_regs && ld_prev), 32'd0);
        ld_prev = ld_regs;
      end else begin
        ld_prev = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld"},    32'(ld_regs),     32'd0);
    chk({tag, "_add"},   32'(add_en),      32'd0);
    chk({tag, "_shift"}, 32'(shift_en),    32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_done"},  32'(done_valid),  32'd0);
    chk({tag, "_ready"}, 32'(start_ready), 32'd1);
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
    int k = 0;
    while (!start_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("start_ready_wait", 32'(start_ready), 32'd1);
    mcand = a; mplier = b; start_valid = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(posedge clk); #1;
    start_valid = 1'b0;
    abort = 1'b0;
    chk("load_after_start", 32'(ld_regs), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("done_wait", 32'(done_valid), 32'd1);
  endtask

  task automatic finish_op(input int hold);
    wait_done();
    for (int i = 0; i < hold; i++) begin
      chk("done_hold", 32'(done_valid), 32'd1);
      chk("hold_start_ready", 32'(start_ready), 32'd0);
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("idle_after_ack", 32'(start_ready), 32'd1);
  endtask

  task automatic wait_strobe(input bit want_add);
    int k = 0;
    while (!(want_add ? add_en : shift_en) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk(want_add ? "wait_add" : "wait_shift", 32'(want_add ? add_en : shift_en), 32'd1);
  endtask

  initial begin
    bit seen_done;
    // Asynchronous reset, no clock edge in between
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("post_rst");

    // Directed operands
    issue(4'd3, 4'd5, 1'b1);  finish_op(0);
    issue(4'd9, 4'd0, 1'b1);  finish_op(1);
    issue(4'd1, 4'd15, 1'b1); finish_op(2);

    // done_ready already high on DONE entry: one-cycle DONE
    done_ready = 1'b1;
    issue(4'd15, 4'd15, 1'b1);
    wait_done();
    @(posedge clk); #1;
    chk("preack_done_len", 32'(done_valid), 32'd0);
    chk("preack_idle", 32'(start_ready), 32'd1);
    done_ready = 1'b0;

    // Hold DONE with start_valid pending; start accepted only from IDLE
    issue(4'd2, 4'd3, 1'b1);
    wait_done();
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_done_valid", 32'(done_valid), 32'd1);
      chk("hold_no_ready", 32'(start_ready), 32'd0);
      chk("hold_no_load", 32'(ld_regs), 32'd0);
      @(posedge clk); #1;
    end
    mcand = 4'd7; mplier = 4'd6;
    sb.push_back(model(4'd7, 4'd6));
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("ack_to_idle", 32'(start_ready), 32'd1);
    chk("ack_done_drop", 32'(done_valid), 32'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("restart_load", 32'(ld_regs), 32'd1);
    finish_op(0);

    // Reset in the middle of ADD
    issue(4'd6, 4'd1, 1'b0);
    wait_strobe(1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid_add");
    @(posedge clk); #1;
    check_reset_outputs("rst_held");
    rst = 1'b0;

    // Abort during SHIFT
    issue(4'd5, 4'd2, 1'b0);
    wait_strobe(1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_ready", 32'(start_ready), 32'd1);
    seen_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_valid) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // Abort alone in IDLE does nothing; with start, start wins
    abort = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_idle_noeffect", 32'(start_ready), 32'd1);
    end
    issue(4'd11, 4'd13, 1'b1);
    finish_op(1);

    // Randomized operands and acknowledge delays
    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      finish_op(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
